// File: rtl/ctrl_seq_pkg.sv
// Shared types for the mode sequencer: state encoding, request payload, mode constants.
// CTRL_MODE_SEQ_GAP_EN adds the break-before-make GAP state.
package ctrl_seq_pkg;

    localparam int unsigned MODE_W = 4;
    localparam logic [MODE_W-1:0] MODE_IDLE = 4'b0000;

    // Default dwell-count width; the request payload is sized from this.
    localparam int unsigned DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef CTRL_MODE_SEQ_GAP_EN
        GAP    = 2'd2,
`endif
        ACTIVE = 2'd1
    } ctrl_seq_state_e;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [DWELL_W-1:0] dwell;
    } ctrl_req_t;

endpackage

// File: rtl/ctrl_intf.sv
// Control interface consumed by the middle/leaf stages; the sequencer is its only driver.
interface ctrl_intf;
    logic                             enable;
    logic [ctrl_seq_pkg::MODE_W-1:0]  mode;

    modport drv (output enable, output mode);
    modport mon (input enable, input mode);
endinterface

// File: rtl/ctrl_req_fifo.sv
// Synchronous request FIFO; extra pointer bit separates full from empty.
module ctrl_req_fifo
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ctrl_req_t push_data,
    input  logic      pop,
    input  logic      flush,
    output ctrl_req_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    ctrl_req_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents are don't-care until a push lands.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ctrl_mode_sequencer.sv
// Applies queued mode requests to ctrl_intf for a programmed dwell each.
// Define CTRL_MODE_SEQ_GAP_EN for a one-cycle enable-low gap between back-to-back entries.
module ctrl_mode_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DWELL_W = ctrl_seq_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MODE_W-1:0]  req_mode,
    input  logic [DWELL_W-1:0] req_dwell,
    input  logic               abort,
    ctrl_intf.drv              ctrl,
    output logic               busy,
    output logic               done
);

    ctrl_seq_state_e    state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               enable_q, enable_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               done_q, done_d;

    ctrl_req_t          push_data;
    ctrl_req_t          fifo_head;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;

    // Ready never looks at a same-cycle pop, so a full queue always back-pressures.
    assign req_ready       = !fifo_full && !abort;
    assign fifo_push       = req_valid && req_ready;
    assign push_data.mode  = req_mode;
    assign push_data.dwell = req_dwell;

    ctrl_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .flush     (abort),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state, dwell counter and output values; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        if (abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            enable_d = 1'b0;
            mode_d   = MODE_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ACTIVE;
                        enable_d = 1'b1;
                        mode_d   = fifo_head.mode;
                        cnt_d    = fifo_head.dwell;
                    end
                end
                ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (!fifo_empty) begin
`ifdef CTRL_MODE_SEQ_GAP_EN
                        // Break before make: drop enable for one cycle, old mode held.
                        state_d  = GAP;
                        enable_d = 1'b0;
`else
                        fifo_pop = 1'b1;
                        mode_d   = fifo_head.mode;
                        cnt_d    = fifo_head.dwell;
`endif
                    end else begin
                        // Queue drained: release enable, keep last mode, flag completion.
                        state_d  = IDLE;
                        enable_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
`ifdef CTRL_MODE_SEQ_GAP_EN
                GAP: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ACTIVE;
                        enable_d = 1'b1;
                        mode_d   = fifo_head.mode;
                        cnt_d    = fifo_head.dwell;
                    end else begin
                        state_d = IDLE;
                    end
                end
`endif
                default: begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            mode_q   <= MODE_IDLE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign ctrl.enable = enable_q;
    assign ctrl.mode   = mode_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule
